skein_nonce_check: RTL and testbench
====================================

# skein_nonce_check

Downstream companion to the Skein-512 hash pipeline. It tracks each nonce issued to the pipeline through a delay line matched to the pipeline latency, then compares the hash that emerges against a 64-bit target. Matching ("golden") nonces are queued in a small FIFO and handed to the host interface over a valid/ready handshake. Free-running statistics counters are also provided.

## Interface

Parameters:
- `LATENCY`, default 108: cycles from nonce acceptance by the hash pipeline to the corresponding `hash` being stable at this block's input. Minimum 1.
- `FIFO_DEPTH`, default 4: number of golden-nonce entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `nonce_in`  in  32  nonce presented to the hash pipeline this cycle.
- `nonce_valid`  in  1  high in the cycle the pipeline accepts `nonce_in`. The hash core accepts on alternate cycles, but this block must not rely on that.
- `hash`  in  512  pipeline hash output, byte-swapped as the core emits it.
- `target`  in  64  unsigned threshold. Quasi-static; sampled every cycle.
- `golden_nonce`  out  32  head-of-FIFO nonce.
- `golden_valid`  out  1  FIFO non-empty.
- `golden_ready`  in  1  consumer accepts the head entry when both `golden_valid` and `golden_ready` are high.
- `hash_count`  out  32  number of delayed-valid compares performed.
- `drop_count`  out  16  number of matches lost to a full FIFO; saturates at 0xFFFF.
- `overflow`  out  1  sticky; set on the first drop.

## Operation

- Delay line: a `LATENCY`-stage shift register of {`nonce_valid`, `nonce_in`}. A nonce accepted at edge k emerges at edge k+LATENCY, aligned with its `hash`.
- Compare stage: at each edge where the delayed valid bit is 1, register the delayed nonce together with the match flag `match = (hash[511:448] <= target)`, unsigned 64-bit compare, equality counts as a match. Increment `hash_count` at the same edge (32-bit, wraps).
- Push: at the following edge, a registered match writes the nonce into the FIFO if it is not full.
  - If the FIFO is full and no pop occurs that edge: discard the nonce, set `overflow`, increment `drop_count`.
  - If the FIFO is full and a pop occurs the same edge: the push succeeds. The pop frees the slot first.
- Pop: on `golden_valid && golden_ready`, advance the read pointer.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - `golden_nonce` is a registered/RAM head value and is stable while `golden_valid=1` and `golden_ready=0`.
- FIFO: circular buffer with log2(`FIFO_DEPTH`)+1-bit read and write pointers that wrap modulo 2·`FIFO_DEPTH`.
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
- Reset: any assertion of `rst`, including mid-stream, clears the following. In-flight nonces are lost, and nonces accepted before the deassertion are never reported.
  - all delay-line valid bits
  - the compare-stage valid bit
  - the FIFO pointers
  - all counters and `overflow`
- Reset values: `golden_valid`=0, `golden_nonce`=0, `hash_count`=0, `drop_count`=0, `overflow`=0.

## Timing

- Nonce accepted at edge k with a matching hash: FIFO write at edge k+LATENCY+1. `golden_valid` is high from that edge onward if the FIFO was previously empty. Total latency is LATENCY+2 cycles to visibility.
- Throughput: one nonce per cycle sustained. There are no stalls and no backpressure toward the hash pipeline.
- `hash_count` updates at edge k+LATENCY. `drop_count` and `overflow` update at edge k+LATENCY+1.
- All outputs are driven from flops. No combinational path exists from `golden_ready` to `golden_valid`.

## Configuration

- `SKEIN_CHECK_HIT_COUNT_EN`: when defined, the block adds an output port `hit_count`, 32 bits, reset 0.
  - It increments at the compare-stage edge for every match, whether or not the match is later dropped, and wraps at 2^32.
- When the macro is undefined, the port and its counter are absent. All other behaviour is identical.

## Test plan

- LATENCY=108. Inject nonce 0x00001234 at edge 0, with `target`=0xFFFFFFFFFFFFFFFF and `hash` driven matching from edge 108 onward -> `golden_valid` rises after edge 109, `golden_nonce`=0x00001234, and `hash_count`=1.
- Boundary compare: `hash[511:448]`=0x0000000100000000 with `target`=0x0000000100000000 -> match. With `target`=0x00000000FFFFFFFF -> no FIFO write, while `hash_count` still increments.
- FIFO_DEPTH=4 with `golden_ready`=0: six consecutive matches (nonces 1..6) -> nonces 1..4 are queued, `drop_count`=2, and `overflow`=1. Then raising `golden_ready` pops 1,2,3,4 in order, and `golden_valid` falls after the 4th pop.
- Full FIFO with `golden_ready`=1 held at the moment a new match pushes -> the push succeeds, `drop_count` is unchanged, and occupancy stays at 4.
- Sustained stream of 1000 back-to-back matching nonces with `golden_ready`=1 -> all 1000 are emitted in order, `hash_count`=1000, and pointer wrap-around is exercised.
- Assert `rst` for one cycle while 50 nonces are in flight and 2 are queued -> all outputs return to their reset values immediately, and none of the 52 nonces ever appear.

Source files
------------

// File: rtl/skein_nonce_check.sv
// Tracks nonces through a latency-matched delay line, compares each emerging hash with the
// target and queues golden nonces. Define SKEIN_CHECK_HIT_COUNT_EN to add the hit_count port.
module skein_nonce_check #(
    parameter int unsigned LATENCY    = 108,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  nonce_in,
    input  logic         nonce_valid,
    input  logic [511:0] hash,
    input  logic [63:0]  target,
    output logic [31:0]  golden_nonce,
    output logic         golden_valid,
    input  logic         golden_ready,
    output logic [31:0]  hash_count,
    output logic [15:0]  drop_count,
`ifdef SKEIN_CHECK_HIT_COUNT_EN
    output logic [31:0]  hit_count,
`endif
    output logic         overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Delay line: only the valid bits need clearing on reset
    logic [LATENCY-1:0] dl_valid;
    logic [31:0]        dl_nonce [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= nonce_valid;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dl_nonce[0] <= nonce_in;
        for (int i = 1; i < int'(LATENCY); i++) begin
            dl_nonce[i] <= dl_nonce[i-1];
        end
    end

    logic dl_out_valid;
    logic hash_hit;

    assign dl_out_valid = dl_valid[LATENCY-1];
    assign hash_hit     = (hash[511:448] <= target);

    // Compare stage: cmp_hit is the registered (valid && match) flag
    logic        cmp_hit;
    logic [31:0] cmp_nonce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_hit    <= 1'b0;
            cmp_nonce  <= '0;
            hash_count <= '0;
        end else begin
            cmp_hit   <= dl_out_valid && hash_hit;
            cmp_nonce <= dl_nonce[LATENCY-1];
            if (dl_out_valid) begin
                hash_count <= hash_count + 32'd1;
            end
        end
    end

`ifdef SKEIN_CHECK_HIT_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (dl_out_valid && hash_hit) begin
            hit_count <= hit_count + 32'd1;
        end
    end
`endif

    // Golden-nonce FIFO
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [31:0]   mem [FIFO_DEPTH];
    logic          full, pop, push, drop;
    logic [31:0]   head_d;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = golden_valid && golden_ready;
    assign push     = cmp_hit && (!full || pop);
    assign drop     = cmp_hit && full && !pop;
    assign wr_ptr_d = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr + {{AW{1'b0}}, pop};

    // A push landing in the new head slot only happens when the FIFO drains to empty
    assign head_d = (push && (wr_ptr[AW-1:0] == rd_ptr_d[AW-1:0])) ? cmp_nonce
                                                                    : mem[rd_ptr_d[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cmp_nonce;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            golden_valid <= 1'b0;
            golden_nonce <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_d;
            rd_ptr       <= rd_ptr_d;
            golden_valid <= (wr_ptr_d != rd_ptr_d);
            if (wr_ptr_d != rd_ptr_d) begin
                golden_nonce <= head_d;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_skein_nonce_check.sv
// Bench for skein_nonce_check: directed scenarios plus random traffic against a queue model.
module tb_skein_nonce_check;

    localparam int unsigned LAT   = 108;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  nonce_in;
    logic         nonce_valid;
    logic [511:0] hash;
    logic [63:0]  target;
    logic [31:0]  golden_nonce;
    logic         golden_valid;
    logic         golden_ready;
    logic [31:0]  hash_count;
    logic [15:0]  drop_count;
    logic         overflow;
`ifdef SKEIN_CHECK_HIT_COUNT_EN
    logic [31:0]  hit_count;
`endif

    skein_nonce_check #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .nonce_in     (nonce_in),
        .nonce_valid  (nonce_valid),
        .hash         (hash),
        .target       (target),
        .golden_nonce (golden_nonce),
        .golden_valid (golden_valid),
        .golden_ready (golden_ready),
        .hash_count   (hash_count),
        .drop_count   (drop_count),
`ifdef SKEIN_CHECK_HIT_COUNT_EN
        .hit_count    (hit_count),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: nonces in flight tagged with their acceptance cycle, FIFO as a queue
    typedef struct {
        int unsigned cyc;
        logic [31:0] nonce;
    } flight_t;

    flight_t      inflight[$];
    logic [31:0]  gq[$];
    int unsigned  cyc = 0;
    logic         pend;
    logic [31:0]  pend_nonce;
    logic [31:0]  m_hash_count;
    logic [31:0]  m_hit_count;
    logic [15:0]  m_drop;
    logic         m_ovf;

    task automatic model_reset();
        inflight.delete();
        gq.delete();
        pend         = 1'b0;
        pend_nonce   = '0;
        m_hash_count = '0;
        m_hit_count  = '0;
        m_drop       = '0;
        m_ovf        = 1'b0;
    endtask

    task automatic model_edge();
        bit pop;
        if (rst) begin
            model_reset();
        end else begin
            pop = (gq.size() != 0) && golden_ready;
            if (pop) void'(gq.pop_front());
            if (pend) begin
                if (gq.size() < int'(DEPTH)) begin
                    gq.push_back(pend_nonce);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
            pend = 1'b0;
            if (inflight.size() != 0 && inflight[0].cyc + LAT == cyc) begin
                flight_t f;
                f = inflight.pop_front();
                m_hash_count++;
                if (hash[511:448] <= target) begin
                    pend       = 1'b1;
                    pend_nonce = f.nonce;
                    m_hit_count++;
                end
            end
            if (nonce_valid) inflight.push_back('{cyc, nonce_in});
        end
        cyc++;
    endtask

    task automatic check_outputs();
        check("golden_valid", golden_valid, gq.size() != 0);
        if (gq.size() != 0) check("golden_nonce", golden_nonce, gq[0]);
        check("hash_count", hash_count, m_hash_count);
        check("drop_count", drop_count, m_drop);
        check("overflow", overflow, m_ovf);
`ifdef SKEIN_CHECK_HIT_COUNT_EN
        check("hit_count", hit_count, m_hit_count);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] n, input logic [63:0] top);
        nonce_valid = v;
        nonce_in    = n;
        for (int w = 0; w < 14; w++) hash[w*32 +: 32] = $urandom();
        hash[511:448] = top;
    endtask

    task automatic pulse_reset();
        nonce_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_golden_nonce", golden_nonce, 32'd0);
        check_outputs();
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input logic [63:0] top);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom(), top);
            step();
        end
    endtask

    initial begin
        golden_ready = 1'b0;
        target       = '1;
        drive(1'b0, 32'd0, 64'd0);
        model_reset();
        pulse_reset();

        // Single matching nonce: visible LATENCY+2 cycles after acceptance
        drive(1'b1, 32'h0000_1234, 64'd0);
        step();
        idle(LAT + 1, {$urandom(), $urandom()});
        check("t1_nonce", golden_nonce, 32'h0000_1234);
        check("t1_count", hash_count, 32'd1);
        golden_ready = 1'b1;
        step();
        golden_ready = 1'b0;

        // Boundary compare: equal matches, one above does not
        target = 64'h0000_0001_0000_0000;
        drive(1'b1, 32'h0000_0B0B, 64'h0000_0001_0000_0000);
        step();
        idle(LAT + 2, 64'h0000_0001_0000_0000);
        check("eq_match", golden_nonce, 32'h0000_0B0B);
        golden_ready = 1'b1;
        step();
        golden_ready = 1'b0;
        target = 64'h0000_0000_FFFF_FFFF;
        drive(1'b1, 32'h0000_0C0C, 64'h0000_0001_0000_0000);
        step();
        idle(LAT + 2, 64'h0000_0001_0000_0000);
        check("gt_nomatch", golden_valid, 1'b0);
        check("gt_count", hash_count, 32'd3);

        // Six matches into a 4-deep FIFO with no consumer
        pulse_reset();
        target = '1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i, {$urandom(), $urandom()});
            step();
        end
        idle(LAT + 4, 64'd0);
        check("ovf_drop", drop_count, 16'd2);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_head", golden_nonce, 32'd1);
        golden_ready = 1'b1;
        idle(5, 64'd0);
        check("ovf_drained", golden_valid, 1'b0);
        golden_ready = 1'b0;

        // Full FIFO with a pop in the same cycle as a push
        pulse_reset();
        for (int i = 0; i < int'(LAT) + 7; i++) begin
            drive((i < 4) || (i == 5), 32'h100 + i, {$urandom(), $urandom()});
            golden_ready = (i == 5 + int'(LAT) + 1);
            step();
        end
        golden_ready = 1'b0;
        check("fullpop_drop", drop_count, 16'd0);
        check("fullpop_head", golden_nonce, 32'h101);
        golden_ready = 1'b1;
        idle(3, 64'd0);
        check("fullpop_occ4", golden_valid, 1'b1);
        idle(1, 64'd0);
        check("fullpop_empty", golden_valid, 1'b0);
        golden_ready = 1'b0;

        // Sustained back-to-back stream with a ready consumer
        pulse_reset();
        golden_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 32'h5000_0000 + i * 7, {$urandom(), $urandom()});
            step();
        end
        idle(LAT + 3, 64'd0);
        check("stream_count", hash_count, 32'd1000);
        check("stream_empty", golden_valid, 1'b0);

        // Random traffic, ~50% match rate, sporadic consumer
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) target = {$urandom(), $urandom()};
            golden_ready = ($urandom_range(0, 9) < 4);
            drive(1'($urandom_range(0, 1)), $urandom(), {$urandom(), $urandom()});
            step();
        end
        golden_ready = 1'b1;
        idle(LAT + 8, {$urandom(), $urandom()});

        // Mid-stream reset with 2 queued and 50 in flight
        pulse_reset();
        golden_ready = 1'b0;
        target = '1;
        drive(1'b1, 32'h0000_0AA1, 64'd0);
        step();
        drive(1'b1, 32'h0000_0AA2, 64'd0);
        step();
        idle(LAT + 2, 64'd0);
        check("pre_rst_queued", golden_nonce, 32'h0000_0AA1);
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 32'h0000_0C00 + i, 64'd0);
            step();
        end
        pulse_reset();
        golden_ready = 1'b1;
        idle(LAT + 10, 64'd0);
        check("post_rst_valid", golden_valid, 1'b0);
        check("post_rst_count", hash_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
